ccff_chain_loader: RTL

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_chain_loader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ccff_chain_loader.sv
// Streams a word-wide bitstream MSB-first into a ccff configuration chain, with an
// optional flush pass that checks the chain tail against the first bits loaded.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 36,
  parameter int WORD_W    = 8,
  parameter bit READBACK  = 1'b0
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int             WCW   = $clog2(WORD_W + 1);
  localparam int             CAP_W = (CHAIN_LEN < 32) ? CHAIN_LEN : 32;
  localparam logic [15:0]    LEN16 = 16'(CHAIN_LEN);
  localparam logic [15:0]    CAP16 = 16'(CAP_W);
  localparam logic [WCW-1:0] WLEN  = WCW'(WORD_W);
  localparam logic [WCW-1:0] WONE  = WCW'(1'b1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [15:0]       bit_cnt_q, bit_cnt_d;
  logic [15:0]       rb_cnt_q, rb_cnt_d;
  logic [WCW-1:0]    wbit_q, wbit_d;
  logic [31:0]       cap_q, cap_d;
  logic              head_q, head_d;
  logic              shen_q, shen_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              emit_s;
  logic [WORD_W-1:0] src_s;

  // Next-state, counter and output computation; emit_s marks a cycle that drives a new bit.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    rb_cnt_d  = rb_cnt_q;
    wbit_d    = wbit_q;
    cap_d     = cap_q;
    err_d     = err_q;
    head_d    = 1'b0;
    shen_d    = 1'b0;
    emit_s    = 1'b0;
    src_s     = '0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d   = S_LOAD;
            bit_cnt_d = 16'd0;
            rb_cnt_d  = 16'd0;
            wbit_d    = '0;
            cap_d     = 32'd0;
            err_d     = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        S_LOAD: begin
          if (bs_valid) begin
            emit_s  = 1'b1;
            src_s   = bs_data;
            wbit_d  = WONE;
            state_d = S_SHIFT;
          end else begin
            state_d = S_LOAD;
          end
        end
        S_SHIFT: begin
          // The chain length check wins over word exhaustion so a partial word is dropped.
          if (bit_cnt_q == LEN16) begin
            if (READBACK) begin
              state_d = S_FLUSH;
              shen_d  = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end else if (wbit_q == WLEN) begin
            state_d = S_LOAD;
          end else begin
            emit_s = 1'b1;
            src_s  = sreg_q;
            wbit_d = wbit_q + WONE;
          end
        end
        S_FLUSH: begin
          if ((rb_cnt_q < CAP16) && (ccff_tail != cap_q[rb_cnt_q[4:0]])) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          rb_cnt_d = rb_cnt_q + 16'd1;
          if (rb_cnt_d == LEN16) begin
            state_d = S_DONE;
          end else begin
            shen_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    if (emit_s) begin
      head_d    = src_s[WORD_W-1];
      shen_d    = 1'b1;
      sreg_d    = src_s << 1'b1;
      bit_cnt_d = bit_cnt_q + 16'd1;
    end else begin
      sreg_d = sreg_d;
    end
    if (emit_s && (bit_cnt_q < CAP16)) begin
      cap_d[bit_cnt_q[4:0]] = src_s[WORD_W-1];
    end else begin
      cap_d = cap_d;
    end
    ready_d = (state_d == S_LOAD);
    busy_d  = (state_d inside {S_LOAD, S_SHIFT, S_FLUSH});
    done_d  = (state_d == S_DONE);
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q   <= S_IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= 16'd0;
      rb_cnt_q  <= 16'd0;
      wbit_q    <= '0;
      cap_q     <= 32'd0;
      head_q    <= 1'b0;
      shen_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      rb_cnt_q  <= rb_cnt_d;
      wbit_q    <= wbit_d;
      cap_q     <= cap_d;
      head_q    <= head_d;
      shen_q    <= shen_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bs_ready      = ready_q;
  assign ccff_head     = head_q;
  assign ccff_shift_en = shen_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
endmodule
